// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter write sequencer.
package blit_pkg;
  localparam int PHRASE_BITS = 64;
  localparam int REM_W       = 22;

  typedef enum logic [1:0] {IDLE, DATA, ZED, FIN} blit_state_e;

  localparam logic [1:0] DSEL_PATD = 2'b00;
  localparam logic [1:0] DSEL_LFU  = 2'b01;
  localparam logic [1:0] DSEL_ADDQ = 2'b10;
  localparam logic [1:0] DSEL_ZED  = 2'b11;

  // DSEL_ZED is reserved for the Z phase, so a request for it falls back to LFU
  function automatic logic [1:0] coerce_sel(input logic [1:0] s);
    return (s == DSEL_ZED) ? DSEL_LFU : s;
  endfunction

  function automatic logic [2:0] clamp_ps(input logic [2:0] p);
    return (p > 3'd5) ? 3'd5 : p;
  endfunction
endpackage

// File: rtl/blit_write_seq_if.sv
// Command and phrase-write bus of the blitter write sequencer.
interface blit_write_seq_if;
  logic        start;
  logic [15:0] count;
  logic [2:0]  pixsize;
  logic [5:0]  x_offset;
  logic [1:0]  src_sel;
  logic        zwrite;
  logic        abort;
  logic        wr_ack;
  logic        wr_req;
  logic [1:0]  data_sel;
  logic        data_ena;
  logic [5:0]  dstart;
  logic [5:0]  dend;
  logic [15:0] phrase_idx;
  logic        busy;
  logic        done;

  // master: the sequencer itself; slave: the command source / memory side
  modport master (
    input  start, count, pixsize, x_offset, src_sel, zwrite, abort, wr_ack,
    output wr_req, data_sel, data_ena, dstart, dend, phrase_idx, busy, done
  );
  modport slave (
    output start, count, pixsize, x_offset, src_sel, zwrite, abort, wr_ack,
    input  wr_req, data_sel, data_ena, dstart, dend, phrase_idx, busy, done
  );
endinterface

// File: rtl/blit_phrase_calc.sv
// Phrase mask and consumed-bit calculation for one 64-bit phrase.
module blit_phrase_calc
  import blit_pkg::*;
(
  input  logic [5:0]       offset,
  input  logic [REM_W-1:0] remaining,
  output logic [5:0]       dstart,
  output logic [5:0]       dend,
  output logic [REM_W-1:0] consumed
);
  logic [REM_W-1:0] avail;

  always_comb begin
    avail  = REM_W'(PHRASE_BITS) - REM_W'(offset);
    dstart = offset;
    if (remaining <= avail) begin
      // wraps to 0 when the span ends exactly on the phrase boundary
      dend     = offset + remaining[5:0];
      consumed = remaining;
    end else begin
      dend     = '0;
      consumed = avail;
    end
  end
endmodule

// File: rtl/blit_write_seq.sv
// Blitter span write sequencer: splits a pixel span into masked phrase writes.
// Define BLIT_ZWRITE_EN to add a Z-buffer write phase after each data phrase.
module blit_write_seq
  import blit_pkg::*;
(
  input  logic             sys_clk,
  input  logic             reset,
  blit_write_seq_if.master bus
);
  blit_state_e      state;
  logic [REM_W-1:0] rem, cur_cons, nxt_rem, c_cons;
  logic [5:0]       nxt_off, c_dstart, c_dend;
  logic [1:0]       src_q;
  logic             z_next;

  logic        wr_req_q, data_ena_q, busy_q, done_q;
  logic [1:0]  data_sel_q;
  logic [5:0]  dstart_q, dend_q;
  logic [15:0] idx_q;

  // The calculator always looks at the phrase that would be loaded next,
  // so the registered mask is ready on the same edge as the state change.
  always_comb begin
    if (state == IDLE) begin
      nxt_rem = REM_W'(bus.count) << clamp_ps(bus.pixsize);
      nxt_off = bus.x_offset;
    end else begin
      nxt_rem = rem - cur_cons;
      nxt_off = '0;
    end
  end

  blit_phrase_calc u_calc (
    .offset   (nxt_off),
    .remaining(nxt_rem),
    .dstart   (c_dstart),
    .dend     (c_dend),
    .consumed (c_cons)
  );

`ifdef BLIT_ZWRITE_EN
  logic zw_q;
  assign z_next = (state == DATA) && zw_q;
`else
  logic unused_zw;
  assign unused_zw = bus.zwrite;
  assign z_next    = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rem        <= '0;
      cur_cons   <= '0;
      src_q      <= '0;
      wr_req_q   <= 1'b0;
      data_ena_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_sel_q <= '0;
      dstart_q   <= '0;
      dend_q     <= '0;
      idx_q      <= '0;
`ifdef BLIT_ZWRITE_EN
      zw_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state      <= IDLE;
        wr_req_q   <= 1'b0;
        data_ena_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            rem    <= nxt_rem;
            src_q  <= coerce_sel(bus.src_sel);
            idx_q  <= '0;
            busy_q <= 1'b1;
`ifdef BLIT_ZWRITE_EN
            zw_q   <= bus.zwrite;
`endif
            if (bus.count != '0) begin
              state      <= DATA;
              wr_req_q   <= 1'b1;
              data_ena_q <= 1'b1;
              dstart_q   <= c_dstart;
              dend_q     <= c_dend;
              cur_cons   <= c_cons;
              data_sel_q <= coerce_sel(bus.src_sel);
            end else begin
              state  <= FIN;
              done_q <= 1'b1;
            end
          end
          DATA, ZED: if (bus.wr_ack) begin
            if (z_next) begin
              state      <= ZED;
              data_sel_q <= DSEL_ZED;
            end else begin
              rem   <= nxt_rem;
              idx_q <= idx_q + 16'd1;
              if (nxt_rem == '0) begin
                state      <= FIN;
                wr_req_q   <= 1'b0;
                data_ena_q <= 1'b0;
                done_q     <= 1'b1;
              end else begin
                state      <= DATA;
                dstart_q   <= c_dstart;
                dend_q     <= c_dend;
                cur_cons   <= c_cons;
                data_sel_q <= src_q;
              end
            end
          end
          FIN: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.wr_req     = wr_req_q;
  assign bus.data_ena   = data_ena_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.data_sel   = data_sel_q;
  assign bus.dstart     = dstart_q;
  assign bus.dend       = dend_q;
  assign bus.phrase_idx = idx_q;
endmodule

// File: tb/tb_blit_write_seq.sv
// Self-checking bench for blit_write_seq: span-level phrase model plus directed spans.
module tb_blit_write_seq;
  import blit_pkg::*;

  logic sys_clk = 1'b0;
  logic reset;
  blit_write_seq_if bif();

  blit_write_seq dut (.sys_clk(sys_clk), .reset(reset), .bus(bif));

  always #5 sys_clk = ~sys_clk;

  typedef struct { int ds; int de; int sel; int idx; } wr_t;
  wr_t exp_q[$];
  int  n_chk = 0, n_fail = 0, dn_cnt = 0;
  bit  m_busy = 0, m_done = 0, force_ack = 0;
  int  ack_pct = 100;
`ifdef BLIT_ZWRITE_EN
  bit  z_en = 1;
`else
  bit  z_en = 0;
`endif

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected phrase writes of a span, straight from the bit-count arithmetic
  function automatic void build(int cnt, int ps, int xo, int src, bit zw);
    int rem, off, idx, avail, take, de, sel;
    ps  = (ps > 5) ? 5 : ps;
    sel = (src == 3) ? 1 : src;
    rem = cnt << ps;
    off = xo;
    idx = 0;
    while (rem > 0) begin
      avail = 64 - off;
      if (rem <= avail) begin de = (off + rem) % 64; take = rem; end
      else begin de = 0; take = avail; end
      exp_q.push_back('{off, de, sel, idx & 16'hffff});
      if (zw && z_en) exp_q.push_back('{off, de, 3, idx & 16'hffff});
      rem -= take;
      off  = 0;
      idx++;
    end
  endfunction

  // Compare process: checks outputs each cycle, then advances the model
  always @(negedge sys_clk) begin
    bit nd;
    if (reset) begin
      exp_q.delete();
      m_busy = 0;
      m_done = 0;
    end else begin
      chk("busy", bif.busy, m_busy);
      chk("done", bif.done, m_done);
      chk("wr_req", bif.wr_req, exp_q.size() > 0);
      chk("data_ena", bif.data_ena, bif.wr_req);
      if (bif.wr_req && exp_q.size() > 0) begin
        chk("dstart", bif.dstart, exp_q[0].ds);
        chk("dend", bif.dend, exp_q[0].de);
        chk("data_sel", bif.data_sel, exp_q[0].sel);
        chk("phrase_idx", bif.phrase_idx, exp_q[0].idx);
      end
      if (bif.done) dn_cnt++;
      nd = 0;
      if (bif.abort && m_busy) begin
        exp_q.delete();
        m_busy = 0;
      end else if (!m_busy && bif.start) begin
        build(bif.count, bif.pixsize, bif.x_offset, bif.src_sel, bif.zwrite);
        m_busy = 1;
        if (exp_q.size() == 0) nd = 1;
      end else if (m_done) begin
        m_busy = 0;
      end else if (exp_q.size() > 0 && bif.wr_ack) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) nd = 1;
      end
      m_done = nd;
    end
  end

  initial begin
    bif.wr_ack = 1'b0;
    forever begin
      @(posedge sys_clk); #2;
      bif.wr_ack = force_ack || ($urandom_range(0, 99) < ack_pct);
    end
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic launch(int cnt, int ps, int xo, int src, bit zw);
    tick();
    bif.count = 16'(cnt); bif.pixsize = 3'(ps); bif.x_offset = 6'(xo);
    bif.src_sel = 2'(src); bif.zwrite = zw; bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
  endtask

  task automatic wait_idle(int max);
    for (int i = 0; i < max; i++) begin
      if (!bif.busy) break;
      tick();
    end
    chk("span_end_busy", bif.busy, 0);
  endtask

  task automatic ack1();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
  endtask

  task automatic phrase(string nm, int ds, int de, int sel, int idx);
    chk({nm, "_req"}, bif.wr_req, 1);
    chk({nm, "_ds"}, bif.dstart, ds);
    chk({nm, "_de"}, bif.dend, de);
    chk({nm, "_sel"}, bif.data_sel, sel);
    chk({nm, "_idx"}, bif.phrase_idx, idx);
  endtask

  int d0;
  int tbl [4][5] = '{'{1, 0, 63, 0, 0}, '{5, 5, 60, 1, 1}, '{100, 2, 7, 2, 0}, '{3, 1, 62, 0, 1}};

  initial begin
    reset = 1'b1;
    bif.start = 0; bif.count = 0; bif.pixsize = 0; bif.x_offset = 0;
    bif.src_sel = 0; bif.zwrite = 0; bif.abort = 0;
    repeat (3) tick();
    chk("rst_wr_req", bif.wr_req, 0);
    chk("rst_data_ena", bif.data_ena, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_data_sel", bif.data_sel, 0);
    chk("rst_dstart", bif.dstart, 0);
    chk("rst_dend", bif.dend, 0);
    chk("rst_idx", bif.phrase_idx, 0);
    reset = 1'b0;
    ack_pct = 0;

    // one full phrase, done one cycle after the ack
    launch(8, 3, 0, 1, 0);
    phrase("t1", 0, 0, 1, 0);
    ack1();
    chk("t1_done", bif.done, 1);
    chk("t1_busy", bif.busy, 1);
    tick();
    chk("t1_done_off", bif.done, 0);
    chk("t1_idle", bif.busy, 0);

    // offset start spilling into a second phrase
    launch(10, 3, 16, 0, 0);
    phrase("t2a", 16, 0, 0, 0);
    ack1();
    phrase("t2b", 0, 32, 0, 1);
    ack1();
    chk("t2_done", bif.done, 1);
    wait_idle(10);

    // Z phase (ignored unless compiled in)
    launch(4, 4, 0, 2, 1);
    phrase("t3a", 0, 0, 2, 0);
    ack1();
    if (z_en) begin
      phrase("t3z", 0, 0, 3, 0);
      ack1();
    end
    chk("t3_done", bif.done, 1);
    chk("t3_req_off", bif.wr_req, 0);
    wait_idle(10);

    // ack withheld five cycles, then abort wins over a simultaneous ack
    launch(20, 3, 8, 1, 0);
    repeat (5) tick();
    phrase("t4_hold", 8, 0, 1, 0);
    d0 = dn_cnt;
    bif.abort = 1'b1; force_ack = 1'b1;
    tick();
    bif.abort = 1'b0; force_ack = 1'b0;
    chk("t4_busy", bif.busy, 0);
    chk("t4_req", bif.wr_req, 0);
    repeat (3) tick();
    chk("t4_no_done", dn_cnt, d0);

    // zero-length span, start during its busy cycle ignored
    d0 = dn_cnt;
    launch(0, 3, 0, 0, 0);
    chk("t5_busy", bif.busy, 1);
    chk("t5_done", bif.done, 1);
    chk("t5_req", bif.wr_req, 0);
    bif.count = 16'd5; bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    chk("t5_busy_off", bif.busy, 0);
    tick();
    chk("t5_ignored", bif.busy, 0);
    chk("t5_done_cnt", dn_cnt, d0 + 1);

    // pixsize 7 clamps to 32bpp, src 11 coerces to lfu
    launch(3, 7, 0, 3, 0);
    phrase("t7a", 0, 0, 1, 0);
    ack1();
    phrase("t7b", 0, 32, 1, 1);
    ack1();
    chk("t7_done", bif.done, 1);
    wait_idle(10);

    // long span with random acks and a start pulse mid-span
    ack_pct = 50;
    d0 = dn_cnt;
    launch(40, 4, 40, 2, 0);
    repeat (3) tick();
    bif.count = 16'd1; bif.x_offset = 6'd0; bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    wait_idle(500);
    chk("t6_done_cnt", dn_cnt, d0 + 1);

    ack_pct = 70;
    foreach (tbl[i]) begin
      d0 = dn_cnt;
      launch(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4] != 0);
      wait_idle(500);
      chk("tbl_done_cnt", dn_cnt, d0 + 1);
    end

    // asynchronous reset mid-span
    ack_pct = 0;
    launch(50, 3, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("t9_req_async", bif.wr_req, 0);
    chk("t9_busy_async", bif.busy, 0);
    tick();
    reset = 1'b0;
    d0 = dn_cnt;
    repeat (4) tick();
    chk("t9_no_done", dn_cnt, d0);

    ack_pct = 100;
    launch(2, 5, 0, 0, 0);
    wait_idle(20);
    chk("t9_recover", dn_cnt, d0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
